// File: rtl/result_drain_buf.sv
// Result buffer with a four-phase valid/ack drain controller.
// Compute side fills the buffer; the host receives the words one at a time once the batch is complete.
module result_drain_buf #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              ovf,
    input  logic              drain_start,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ack,
    output logic              drain_done
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_SHOW,
        S_REL,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              ovf_q, ovf_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              do_wr;
    logic              do_pop;

    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign ovf      = ovf_q;
    assign out_data = out_data_q;

    // clr outranks every other input, so it masks both data movements
    assign do_wr  = wr_req && !full && !clr;
    assign do_pop = (state_q == S_POP) && !clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else if (clr) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (drain_start) begin
                    state_d = empty ? S_DONE : S_POP;
                end
            end
            S_POP:  state_d = S_SHOW;
            S_SHOW: begin
                if (out_ack) begin
                    state_d = S_REL;
                end
            end
            // Empty test sees words written during the drain as well
            S_REL: begin
                if (!out_ack) begin
                    state_d = empty ? S_DONE : S_POP;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        out_valid  = 1'b0;
        drain_done = 1'b0;
        unique case (state_q)
            S_SHOW:  out_valid  = 1'b1;
            S_DONE:  drain_done = 1'b1;
            default: begin
                out_valid  = 1'b0;
                drain_done = 1'b0;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        out_data_d = out_data_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            out_data_d = mem_q[rd_ptr_q];
        end
        unique case ({do_wr, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (wr_req && full) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            out_data_q <= '0;
        end else if (clr) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            out_data_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            out_data_q <= out_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_result_drain_buf.sv
// Bench for result_drain_buf: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_result_drain_buf;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        wr_req = 1'b0;
    logic [15:0] wr_data = '0;
    logic        full, empty, ovf;
    logic [3:0]  count;
    logic        drain_start = 1'b0;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ack = 1'b0;
    logic        drain_done;

    result_drain_buf #(.DATA_W(16), .DEPTH(8), .ADDR_W(3)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .wr_req(wr_req), .wr_data(wr_data),
        .full(full), .empty(empty), .count(count), .ovf(ovf),
        .drain_start(drain_start),
        .out_data(out_data), .out_valid(out_valid),
        .out_ack(out_ack), .drain_done(drain_done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int failed = 0;

    function automatic void chk(string nm, int act, int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: FIFO contents as a queue, host phase as a small integer
    // 0 idle, 1 fetching, 2 presenting, 3 waiting release, 4 done pulse
    logic [15:0] mq[$];
    int          mph = 0;
    logic [15:0] m_out = '0;
    bit          m_ovf = 0;

    always @(posedge clk or posedge rst) begin
        if (rst || clr) begin
            mq.delete();
            mph   = 0;
            m_out = '0;
            m_ovf = 0;
        end else begin
            bit room;
            bit was_empty;
            room      = (mq.size() < 8);
            was_empty = (mq.size() == 0);
            if (wr_req && !room) m_ovf = 1;
            case (mph)
                0: if (drain_start) mph = was_empty ? 4 : 1;
                1: begin m_out = mq.pop_front(); mph = 2; end
                2: if (out_ack) mph = 3;
                3: if (!out_ack) mph = was_empty ? 4 : 1;
                default: mph = 0;
            endcase
            if (wr_req && room) mq.push_back(wr_data);
        end
    end

    logic [15:0] seen[$];
    int          nrise = 0;
    int          ndone = 0;
    bit          pv = 0;

    always @(negedge clk) begin
        chk("count", int'(count), mq.size());
        chk("full", int'(full), int'(mq.size() == 8));
        chk("empty", int'(empty), int'(mq.size() == 0));
        chk("ovf", int'(ovf), int'(m_ovf));
        chk("out_valid", int'(out_valid), int'(mph == 2));
        chk("drain_done", int'(drain_done), int'(mph == 4));
        chk("out_data", int'(out_data), int'(m_out));
        if (out_valid && !pv) begin
            seen.push_back(out_data);
            nrise++;
        end
        pv = out_valid;
        if (drain_done) ndone++;
    end

    // Host: 0 random ack/release delays, 1 hold ack for 6 extra cycles, 2 never ack
    int ack_mode = 0;
    int hold_cnt = 0;

    always @(negedge clk) begin
        if (ack_mode == 0) begin
            if (!out_ack && out_valid && $urandom_range(0, 2) == 0) out_ack = 1'b1;
            else if (out_ack && !out_valid && $urandom_range(0, 2) == 0) out_ack = 1'b0;
        end else if (ack_mode == 1) begin
            if (!out_ack && out_valid) begin
                out_ack  = 1'b1;
                hold_cnt = 6;
            end else if (out_ack) begin
                if (hold_cnt > 0) hold_cnt--;
                else out_ack = 1'b0;
            end
        end else begin
            out_ack = 1'b0;
        end
    end

    task automatic write_word(input logic [15:0] d);
        wr_req  = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr_req  = 1'b0;
    endtask

    task automatic pulse_start();
        drain_start = 1'b1;
        @(negedge clk);
        drain_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!drain_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", int'(drain_done), 1);
        @(negedge clk);
    endtask

    logic [15:0] exp_q[$];

    initial begin
        int n;
        int snap;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_empty", int'(empty), 1);
        chk("rst_count", int'(count), 0);

        // Fill, overflow, drain in order
        for (int i = 1; i <= 8; i++) write_word(16'(i * 16'h0011));
        #1;
        chk("fill_full", int'(full), 1);
        chk("fill_count", int'(count), 8);
        write_word(16'hDEAD);
        #1;
        chk("ovf_count", int'(count), 8);
        chk("ovf_set", int'(ovf), 1);
        seen.delete();
        ndone = 0;
        pulse_start();
        wait_done(400);
        #1;
        chk("order_len", seen.size(), 8);
        for (int i = 0; i < 8 && i < seen.size(); i++)
            chk("order_word", int'(seen[i]), (i + 1) * 16'h0011);
        chk("done_once", ndone, 1);
        chk("drained_empty", int'(empty), 1);
        chk("ovf_sticky", int'(ovf), 1);
        chk("hold_last", int'(out_data), 16'h0088);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        #1;
        chk("clr_ovf", int'(ovf), 0);

        // Wrap: 5 in, drain while 5 more arrive
        exp_q.delete();
        seen.delete();
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(16'($urandom));
            write_word(exp_q[$]);
        end
        pulse_start();
        n = 0;
        while (seen.size() < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("wrap_wait", int'(seen.size() >= 3), 1);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(16'($urandom));
            write_word(exp_q[$]);
        end
        wait_done(600);
        #1;
        chk("wrap_len", seen.size(), 10);
        for (int i = 0; i < 10 && i < seen.size(); i++)
            chk("wrap_word", int'(seen[i]), int'(exp_q[i]));

        // Long ack hold consumes one word
        for (int i = 0; i < 3; i++) write_word(16'h0A00 + 16'(i));
        ack_mode = 1;
        seen.delete();
        pulse_start();
        n = 0;
        while (!out_ack && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("hold_ack_wait", int'(out_ack), 1);
        repeat (5) @(negedge clk);
        #1;
        chk("hold_count", int'(count), 2);
        chk("hold_valid", int'(out_valid), 0);
        wait_done(400);
        #1;
        chk("hold_words", seen.size(), 3);
        ack_mode = 0;

        // Drain of an empty buffer
        snap  = nrise;
        ndone = 0;
        pulse_start();
        repeat (3) @(negedge clk);
        #1;
        chk("empty_done", ndone, 1);
        chk("empty_novalid", nrise - snap, 0);

        // clr while presenting
        ack_mode = 2;
        @(negedge clk);
        for (int i = 0; i < 5; i++) write_word(16'h0B00 + 16'(i));
        pulse_start();
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("clr_show", int'(out_valid), 1);
        chk("clr_left", int'(count), 4);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        #1;
        chk("clr_valid", int'(out_valid), 0);
        chk("clr_count", int'(count), 0);
        ndone = 0;
        repeat (4) @(negedge clk);
        #1;
        chk("clr_nodone", ndone, 0);
        chk("clr_data", int'(out_data), 0);
        ack_mode = 0;

        // Asynchronous reset mid-cycle
        for (int i = 0; i < 9; i++) write_word(16'h0C00 + 16'(i));
        #2;
        rst = 1'b1;
        #1;
        chk("arst_empty", int'(empty), 1);
        chk("arst_count", int'(count), 0);
        chk("arst_valid", int'(out_valid), 0);
        chk("arst_ovf", int'(ovf), 0);
        @(negedge clk);
        rst = 1'b0;

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            wr_req      = ($urandom_range(0, 1) == 0);
            wr_data     = 16'($urandom);
            drain_start = ($urandom_range(0, 9) == 0);
            clr         = ($urandom_range(0, 99) == 0);
            @(negedge clk);
        end
        wr_req      = 1'b0;
        drain_start = 1'b0;
        clr         = 1'b0;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
